rr_arbiter4: RTL and testbench



---
 rtl/rr_arbiter4.sv | 133 +++++++++++++
 tb/tb_rr_arbiter4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4 - four-requester round-robin arbiter with a hold limit.
//
// Shares one resource among requesters 0..3. The winning index is
// registered in grant_id_q and then decoded to a one-hot grant vector. So
// there is no combinational path from req to grant. A hold counter bounds
// how long one owner may keep the grant when HOLD_MAX is non-zero.
//
// Handshake: req[i] is a level request. Requester i owns the resource for
// every cycle in which grant[i]=1. It releases the resource by dropping
// req[i], and its grant[i] clears after the edge that samples req[i] low.
// enable only gates new arbitration and never takes away an active grant.
//
// Parameters:
//   HOLD_MAX  maximum consecutive cycles per grant (0..255, 0 = unlimited)
// Ports:
//   clk       clock, rising-edge active
//   rst       asynchronous active-high reset
//   enable    permits new arbitration
//   req[3:0]  level requests
//   grant     one-hot grant; all-zero when not busy
//   grant_id  index of the current or most recent owner
//   busy      1 while a grant is active (exposes the FSM state)
// ---------------------------------------------------------------------------
module rr_arbiter4 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic [7:0] cnt_q, cnt_d;

    logic       release_now;
    logic [1:0] next_ptr;
    logic [1:0] win_cur;
    logic [1:0] win_next;

    // First requester at or after p, in the scan order p, p+1, p+2, p+3 mod 4.
    // The loop runs downwards so that the closest match is the one kept.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] res;
        res = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;

        release_now = !req[grant_id_q] || ((HOLD_MAX != 0) && (cnt_q == HOLD_LIM));
        next_ptr    = grant_id_q + 2'd1;
        win_cur     = pick(req, ptr_q);
        // Re-arbitration on release uses the pointer that is being written on
        // that same edge. So the releasing owner is scanned last.
        win_next    = pick(req, next_ptr);

        case (state_q)
            IDLE: begin
                if (enable && (req != 4'b0000)) begin
                    state_d    = GRANT;
                    grant_id_d = win_cur;
                    cnt_d      = 8'd1;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    ptr_d = next_ptr;
                    if (enable && (req != 4'b0000)) begin
                        // Direct hand-over: there is no idle cycle between owners.
                        grant_id_d = win_next;
                        cnt_d      = 8'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            grant_id_q <= 2'd0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
        end
    end

    // The outputs decode directly from registers. The grant is therefore
    // one-hot or zero by construction.
    assign busy     = (state_q == GRANT);
    assign grant_id = grant_id_q;
    assign grant    = busy ? (4'b0001 << grant_id_q) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4 - self-checking bench for rr_arbiter4.
// Three instances share the stimulus: HOLD_MAX = 4, 3 and 0.
// Each observation is packed as {grant, busy, grant_id}.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] req;

    logic [3:0] g4, g3, g0;
    logic [1:0] id4, id3, id0;
    logic       b4, b3, b0;

    rr_arbiter4 #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .grant(g4), .grant_id(id4), .busy(b4));
    rr_arbiter4 #(.HOLD_MAX(3)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .grant(g3), .grant_id(id3), .busy(b3));
    rr_arbiter4 #(.HOLD_MAX(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .grant(g0), .grant_id(id0), .busy(b0));

    // ---- clock / reset ----------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] obs [3];
    assign obs[0] = {g4, b4, id4};
    assign obs[1] = {g3, b3, id3};
    assign obs[2] = {g0, b0, id0};

    int vectors    = 0;
    int miscompares = 0;

    // Scoreboard entries are {dut index, expected {grant, busy, grant_id}}.
    logic [8:0] exp_q [$];

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] id;
    } vec_t;

    // ---- reference model, one copy per instance ----------------------------
    int         hold   [3] = '{4, 3, 0};
    logic       m_busy [3];
    logic [1:0] m_ptr  [3];
    logic [1:0] m_id   [3];
    int         m_cnt  [3];

    function automatic logic [1:0] first_req(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (r[idx]) return idx;
        end
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 1'b0; m_ptr[k] = 2'd0; m_id[k] = 2'd0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic en, input logic [3:0] rq);
        logic rel;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_busy[k] = 1'b0; m_ptr[k] = 2'd0; m_id[k] = 2'd0; m_cnt[k] = 0;
            end else if (!m_busy[k]) begin
                if (en && rq != 4'b0000) begin
                    m_busy[k] = 1'b1;
                    m_id[k]   = first_req(rq, m_ptr[k]);
                    m_cnt[k]  = 1;
                end
            end else begin
                rel = !rq[m_id[k]] || (hold[k] != 0 && m_cnt[k] == hold[k]);
                if (!rel) begin
                    m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
                end else begin
                    m_ptr[k] = m_id[k] + 2'd1;
                    if (en && rq != 4'b0000) begin
                        m_id[k]  = first_req(rq, m_ptr[k]);
                        m_cnt[k] = 1;
                    end else begin
                        m_busy[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    function automatic logic [6:0] model_obs(input int k);
        logic [3:0] g;
        g = m_busy[k] ? (4'b0001 << m_id[k]) : 4'b0000;
        return {g, m_busy[k], m_id[k]};
    endfunction

    // ---- driver / checker tasks --------------------------------------------
    task automatic drive(input logic r, input logic en, input logic [3:0] rq);
        @(negedge clk);
        rst = r; enable = en; req = rq;
        model_step(r, en, rq);
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got grant=%b busy=%b id=%0d, expected grant=%b busy=%b id=%0d",
                     name, act[6:3], act[2], act[1:0], exp[6:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic drain(input string name);
        logic [8:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(name, obs[e[8:7]], e[6:0]);
        end
    endtask

    // ---- test --------------------------------------------------------------
    vec_t vt [$];

    initial begin
        rst = 1'b1; enable = 1'b0; req = 4'b0000;
        model_reset();

        // Expectations for the HOLD_MAX=4 instance.
        vt = '{
            '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0},   // reset
            '{1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd0},   // enable gating
            '{1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1},   // grant r1 cnt1
            '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1},   // enable low: held
            '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1},
            '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1},   // cnt4
            '{1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1},   // timeout, no enable -> idle, ptr2
            '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1},
            '{1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2},   // fairness from ptr2
            '{1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2},
            '{1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2},
            '{1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2},
            '{1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3},
            '{1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3},
            '{1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3},
            '{1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3},
            '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0},
            '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0},
            '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0},
            '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0},
            '{1'b0, 1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1},
            '{1'b0, 1'b1, 4'b0101, 4'b0100, 1'b1, 2'd2},   // voluntary release of r1
            '{1'b0, 1'b1, 4'b0101, 4'b0100, 1'b1, 2'd2},
            '{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0},   // ptr3 -> wraps to r0
            '{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0},
            '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0},   // idle keeps id
            '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0},
            '{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0},
            '{1'b0, 1'b1, 4'b0011, 4'b0001, 1'b1, 2'd0},   // no preemption
            '{1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1},
            '{1'b0, 1'b1, 4'b0011, 4'b0010, 1'b1, 2'd1},
            '{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0},   // drop/raise r0 -> lowest priority
            '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0}
        };

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].en, vt[i].req);
            exp_q.push_back({2'd0, vt[i].grant, vt[i].busy, vt[i].id});
            @(posedge clk); #1;
            drain($sformatf("vec%0d", i));
        end

        // Asynchronous reset while busy.
        drive(1'b0, 1'b1, 4'b0100);
        @(posedge clk); #1;
        check("async_pre", obs[0], {4'b0100, 1'b1, 2'd2});
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst", obs[0], {4'b0000, 1'b0, 2'd0});
        drive(1'b0, 1'b1, 4'b0001);
        check("rst_no_edge", obs[0], {4'b0000, 1'b0, 2'd0});
        exp_q.push_back({2'd0, 4'b0001, 1'b1, 2'd0});
        @(posedge clk); #1;
        drain("after_rst");

        // Hold timeout: two requesters, HOLD_MAX = 4, 3 and unlimited.
        drive(1'b1, 1'b0, 4'b0000);
        @(posedge clk); #1;
        for (int c = 1; c <= 9; c++) begin
            drive(1'b0, 1'b1, 4'b1100);
            exp_q.push_back({2'd0, (((c - 1) / 4) % 2 == 1) ? 4'b1000 : 4'b0100, 1'b1,
                             (((c - 1) / 4) % 2 == 1) ? 2'd3 : 2'd2});
            exp_q.push_back({2'd1, (((c - 1) / 3) % 2 == 1) ? 4'b1000 : 4'b0100, 1'b1,
                             (((c - 1) / 3) % 2 == 1) ? 2'd3 : 2'd2});
            exp_q.push_back({2'd2, 4'b0100, 1'b1, 2'd2});
            @(posedge clk); #1;
            drain($sformatf("hold_c%0d", c));
        end

        // Random traffic: model compare plus the one-hot invariant on all instances.
        drive(1'b1, 1'b0, 4'b0000);
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] rq;
            rq = (($urandom_range(0, 3)) == 0) ? 4'($urandom_range(0, 15)) : req;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rq);
            for (int k = 0; k < 3; k++) begin
                exp_q.push_back({2'(k), model_obs(k)});
            end
            @(posedge clk); #1;
            drain($sformatf("rand%0d", n));
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (!$onehot0(obs[k][6:3]) ||
                    (obs[k][2] && obs[k][6:3] != (4'b0001 << obs[k][1:0]))) begin
                    miscompares++;
                    $display("FAIL onehot dut%0d cycle %0d: grant=%b busy=%b id=%0d",
                             k, n, obs[k][6:3], obs[k][2], obs[k][1:0]);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
